dut_or_fifo: RTL and testbench
==============================

Name: dut_or_fifo

Overview:
- Register-mapped OR-gate accelerator with FIFO-buffered operands and result.
- Host writes 1-bit operands A and B into input FIFOs through the write port.
- An internal compute step pops one A and one B, computes A|B and pushes the result into the Y FIFO.
- Host polls status and pops results through the read port. The block sits behind a simple address/enable bus wrapper.

Parameters:
- AB_DEPTH, 2, entries in each of the A and B operand FIFOs (>=1).
- Y_DEPTH, 1, entries in the result FIFO (>=1).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- write_address  input  3  write register select.
- write_data  input  1  operand bit to write.
- write_en  input  1  write strobe, one write per cycle.
- write_rdy  output  1  write port ready.
- read_address  input  3  read register select.
- read_en  input  1  read strobe; side effects only when high.
- read_data  output  1  read value.
- read_rdy  output  1  read port ready.

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low. Sampled only on a rising CLK edge with RST_N=0; this empties all FIFOs and clears all state.
- Commands presented during a reset edge are ignored.
- write_rdy and read_rdy are tied to 1. Hosts may write and read in the same cycle.
- Register map (address: access, meaning):
  - 0: R, A_STATUS = 1 when the A FIFO is not full.
  - 1: R, B_STATUS = 1 when the B FIFO is not full.
  - 2: R, Y_STATUS = 1 when the Y FIFO is not empty.
  - 3: R, Y_OUTPUT = Y FIFO head. When read_en=1 and Y is not empty, pop Y at the edge.
  - 4: W, A_DATA, push write_data into the A FIFO.
  - 5: W, B_DATA, push write_data into the B FIFO.
  - 6, 7: R return 0 (see Optional Feature).
- read_data is combinational from read_address and current (pre-edge) state, valid in the same cycle as read_en. With read_en=0 it still reflects the addressed register, with no side effects.
- Y_OUTPUT read while Y is empty returns 0 and does not pop.
- Write with write_en=1 to address 4/5 while the target FIFO is full: data dropped, no state change. Writes to addresses 0-3, 6, 7 are ignored.
- Full/empty decisions use pre-edge state. No pass-through: a write to a full A FIFO is dropped even if compute pops A in the same cycle.
- Compute fires at an edge when A is not empty, B is not empty and Y is not full (pre-edge).
  - On firing: pop A and B, push (A_head | B_head) into Y.
  - A Y pop in the same cycle does not enable compute; Y "not full" is evaluated before the pop.
- Latency example: A written at edge N, B written at edge N+1, compute fires at edge N+2, Y_STATUS reads 1 after edge N+2.
- Compute and host push/pop on the same FIFO in one cycle are all legal. Occupancy updates by (+push - pop).
- FIFOs are circular buffers with wrapping pointers and a count. Order is strictly FIFO.
- After reset: A_STATUS=1, B_STATUS=1, Y_STATUS=0, Y_OUTPUT reads 0.

Optional Feature:
- Macro OVERFLOW_STATUS_EN.
- When defined:
  - Address 6 reads a sticky overflow flag. It is set when any write to address 4/5 is dropped because the FIFO is full.
  - It is cleared by a read of address 6 with read_en=1 and by reset. A set and a clear in the same cycle leaves it set.
- When not defined: address 6 reads 0 and no flag logic exists.

Test Plan:
- Reset, then read addresses 0, 1, 2, 3 -> 1, 1, 0, 0.
- Write A=1 (addr 4), write B=0 (addr 5), wait 2 cycles -> Y_STATUS=1. Read addr 3 with read_en -> 1; next cycle Y_STATUS=0.
- Pairs (0,0), (0,1), (1,1) in sequence, draining Y after each -> Y_OUTPUT 0, 1, 1.
- Write A three times with no B (AB_DEPTH=2) -> A_STATUS=0 after two writes. Third write dropped. With OVERFLOW_STATUS_EN, addr 6 reads 1, then 0 after that read.
- Fill A and B to 2 entries each without draining Y -> exactly one compute occurs, A/B keep 1 entry each. Pop Y -> second result appears on the following edge, in order.
- Assert RST_N=0 for one edge with data pending in all FIFOs -> all FIFOs empty, status reads 1, 1, 0.

Source files
------------

// File: rtl/dut_or_fifo.sv
// Register-mapped OR accelerator: operand FIFOs A/B feed a compute step that pushes A|B into FIFO Y.
// Optional OVERFLOW_STATUS_EN adds a sticky dropped-write flag readable at address 6.
module dut_or_fifo #(
  parameter int unsigned AB_DEPTH = 2,
  parameter int unsigned Y_DEPTH  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] write_address,
  input  logic       write_data,
  input  logic       write_en,
  output logic       write_rdy,
  input  logic [2:0] read_address,
  input  logic       read_en,
  output logic       read_data,
  output logic       read_rdy
);

  localparam int unsigned AB_PW = (AB_DEPTH > 1) ? $clog2(AB_DEPTH) : 1;
  localparam int unsigned AB_CW = $clog2(AB_DEPTH + 1);
  localparam int unsigned Y_PW  = (Y_DEPTH > 1) ? $clog2(Y_DEPTH) : 1;
  localparam int unsigned Y_CW  = $clog2(Y_DEPTH + 1);

  logic [AB_DEPTH-1:0] a_mem, b_mem;
  logic [Y_DEPTH-1:0]  y_mem;
  logic [AB_PW-1:0]    a_wr_ptr, a_rd_ptr, b_wr_ptr, b_rd_ptr;
  logic [Y_PW-1:0]     y_wr_ptr, y_rd_ptr;
  logic [AB_CW-1:0]    a_cnt, b_cnt;
  logic [Y_CW-1:0]     y_cnt;

  logic a_full, a_empty, b_full, b_empty, y_full, y_empty;
  logic a_push, b_push, y_pop, fire, y_in;

  function automatic logic [AB_PW-1:0] ab_next(input logic [AB_PW-1:0] p);
    return (p == AB_PW'(AB_DEPTH - 1)) ? '0 : p + AB_PW'(1);
  endfunction

  function automatic logic [Y_PW-1:0] y_next(input logic [Y_PW-1:0] p);
    return (p == Y_PW'(Y_DEPTH - 1)) ? '0 : p + Y_PW'(1);
  endfunction

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  // All full/empty decisions come from pre-edge occupancy; no pass-through.
  assign a_full  = (a_cnt == AB_CW'(AB_DEPTH));
  assign a_empty = (a_cnt == '0);
  assign b_full  = (b_cnt == AB_CW'(AB_DEPTH));
  assign b_empty = (b_cnt == '0);
  assign y_full  = (y_cnt == Y_CW'(Y_DEPTH));
  assign y_empty = (y_cnt == '0);

  assign a_push = write_en && (write_address == 3'd4) && !a_full;
  assign b_push = write_en && (write_address == 3'd5) && !b_full;
  assign y_pop  = read_en && (read_address == 3'd3) && !y_empty;
  assign fire   = !a_empty && !b_empty && !y_full;
  assign y_in   = a_mem[a_rd_ptr] | b_mem[b_rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_mem    <= '0;
      b_mem    <= '0;
      y_mem    <= '0;
      a_wr_ptr <= '0;
      a_rd_ptr <= '0;
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      y_wr_ptr <= '0;
      y_rd_ptr <= '0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      if (a_push) begin
        a_mem[a_wr_ptr] <= write_data;
        a_wr_ptr        <= ab_next(a_wr_ptr);
      end
      if (b_push) begin
        b_mem[b_wr_ptr] <= write_data;
        b_wr_ptr        <= ab_next(b_wr_ptr);
      end
      if (fire) begin
        a_rd_ptr        <= ab_next(a_rd_ptr);
        b_rd_ptr        <= ab_next(b_rd_ptr);
        y_mem[y_wr_ptr] <= y_in;
        y_wr_ptr        <= y_next(y_wr_ptr);
      end
      if (y_pop) y_rd_ptr <= y_next(y_rd_ptr);
      a_cnt <= a_cnt + AB_CW'(a_push) - AB_CW'(fire);
      b_cnt <= b_cnt + AB_CW'(b_push) - AB_CW'(fire);
      y_cnt <= y_cnt + Y_CW'(fire) - Y_CW'(y_pop);
    end
  end

`ifdef OVERFLOW_STATUS_EN
  logic ovf;
  logic ovf_set;

  assign ovf_set = write_en && (((write_address == 3'd4) && a_full) ||
                                ((write_address == 3'd5) && b_full));

  // Set wins over a same-cycle clearing read.
  always_ff @(posedge CLK) begin
    if (!RST_N)                                  ovf <= 1'b0;
    else if (ovf_set)                            ovf <= 1'b1;
    else if (read_en && (read_address == 3'd6))  ovf <= 1'b0;
  end
`endif

  always_comb begin
    read_data = 1'b0;
    case (read_address)
      3'd0: read_data = !a_full;
      3'd1: read_data = !b_full;
      3'd2: read_data = !y_empty;
      3'd3: read_data = y_empty ? 1'b0 : y_mem[y_rd_ptr];
`ifdef OVERFLOW_STATUS_EN
      3'd6: read_data = ovf;
`endif
      default: read_data = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dut_or_fifo.sv
// Scoreboard bench for dut_or_fifo: a queue model of A/B/Y predicts every read_data value.
module tb_dut_or_fifo;

  localparam int unsigned AB_DEPTH = 2;
  localparam int unsigned Y_DEPTH  = 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] write_address = '0;
  logic       write_data = 1'b0;
  logic       write_en = 1'b0;
  logic       write_rdy;
  logic [2:0] read_address = '0;
  logic       read_en = 1'b0;
  logic       read_data;
  logic       read_rdy;

  int vectors = 0;
  int miscompares = 0;

  // Model operand FIFOs and the result scoreboard (expected Y values in order).
  logic m_a[$];
  logic m_b[$];
  logic sb_y[$];
  logic m_ovf = 1'b0;

  dut_or_fifo #(.AB_DEPTH(AB_DEPTH), .Y_DEPTH(Y_DEPTH)) u_dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .write_address(write_address),
    .write_data(write_data),
    .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address),
    .read_en(read_en),
    .read_data(read_data),
    .read_rdy(read_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_read(input logic [2:0] ra);
    logic v;
    v = 1'b0;
    case (ra)
      3'd0: v = (m_a.size() < AB_DEPTH);
      3'd1: v = (m_b.size() < AB_DEPTH);
      3'd2: v = (sb_y.size() > 0);
      3'd3: v = (sb_y.size() > 0) ? sb_y[0] : 1'b0;
`ifdef OVERFLOW_STATUS_EN
      3'd6: v = m_ovf;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // One clock: drive after negedge, check read_data, advance model with pre-edge state.
  task automatic step(input logic rst, input logic we, input logic [2:0] wa, input logic wd,
                      input logic re, input logic [2:0] ra, input string tag);
    logic a_full, b_full, y_full, fire, ypop, drop, av, bv, yv;
    @(negedge CLK);
    RST_N = ~rst;
    write_en = we;
    write_address = wa;
    write_data = wd;
    read_en = re;
    read_address = ra;
    #1;
    a_full = (m_a.size() == AB_DEPTH);
    b_full = (b_full_q());
    y_full = (sb_y.size() == Y_DEPTH);
    fire = (m_a.size() > 0) && (m_b.size() > 0) && !y_full;
    ypop = re && (ra == 3'd3) && (sb_y.size() > 0);
    drop = we && (((wa == 3'd4) && a_full) || ((wa == 3'd5) && b_full));
    if (ypop) begin
      yv = sb_y.pop_front();
      chk({tag, "_ypop"}, read_data, yv);
    end else begin
      chk(tag, read_data, model_read(ra));
    end
    if (rst) begin
      m_a.delete();
      m_b.delete();
      sb_y.delete();
      m_ovf = 1'b0;
    end else begin
      if (fire) begin
        av = m_a.pop_front();
        bv = m_b.pop_front();
        sb_y.push_back(av | bv);
      end
      if (we && (wa == 3'd4) && !a_full) m_a.push_back(wd);
      if (we && (wa == 3'd5) && !b_full) m_b.push_back(wd);
      if (drop) m_ovf = 1'b1;
      else if (re && (ra == 3'd6)) m_ovf = 1'b0;
    end
    @(posedge CLK);
  endtask

  function automatic logic b_full_q();
    return (m_b.size() == AB_DEPTH);
  endfunction

  task automatic rd(input logic [2:0] ra, input logic re, input string tag);
    step(1'b0, 1'b0, 3'd0, 1'b0, re, ra, tag);
  endtask

  task automatic wr(input logic [2:0] wa, input logic wd, input string tag);
    step(1'b0, 1'b1, wa, wd, 1'b0, 3'd2, tag);
  endtask

  initial begin
    logic we, wd, re, rst;
    logic [2:0] wa, ra;

    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, "rst_hold");
    step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, "rst_cmd_ignored");
    chk("write_rdy", write_rdy, 1'b1);
    chk("read_rdy", read_rdy, 1'b1);

    // Reset state
    rd(3'd0, 1'b0, "rst_a_status");
    rd(3'd1, 1'b0, "rst_b_status");
    rd(3'd2, 1'b0, "rst_y_status");
    rd(3'd3, 1'b1, "rst_y_empty_read");
    rd(3'd6, 1'b0, "rst_addr6");
    rd(3'd7, 1'b0, "rst_addr7");

    // Basic A=1, B=0 latency and pop
    wr(3'd4, 1'b1, "w_a1");
    wr(3'd5, 1'b0, "w_b0");
    rd(3'd2, 1'b0, "lat_y_status_pre");
    rd(3'd2, 1'b0, "lat_y_status");
    rd(3'd3, 1'b1, "y_pop1");
    rd(3'd2, 1'b0, "y_status_after_pop");

    // Operand pairs drained one at a time
    for (int i = 0; i < 3; i++) begin
      wr(3'd4, (i == 2) ? 1'b1 : 1'b0, "pair_a");
      wr(3'd5, (i == 0) ? 1'b0 : 1'b1, "pair_b");
      rd(3'd2, 1'b0, "pair_wait");
      rd(3'd3, 1'b1, "pair_pop");
    end

    // A overflow and sticky flag
    wr(3'd4, 1'b1, "ovf_a1");
    wr(3'd4, 1'b0, "ovf_a2");
    rd(3'd0, 1'b0, "ovf_a_full");
    wr(3'd4, 1'b1, "ovf_a3_drop");
    rd(3'd6, 1'b1, "ovf_flag_read");
    rd(3'd6, 1'b0, "ovf_flag_cleared");
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, "rst2");

    // Fill A and B without draining Y
    wr(3'd4, 1'b0, "fill_a1");
    wr(3'd4, 1'b1, "fill_a2");
    wr(3'd5, 1'b0, "fill_b1");
    wr(3'd5, 1'b1, "fill_b2");
    rd(3'd0, 1'b0, "fill_a_status");
    rd(3'd1, 1'b0, "fill_b_status");
    rd(3'd3, 1'b1, "fill_pop1");
    rd(3'd2, 1'b0, "fill_second_ready");
    rd(3'd3, 1'b1, "fill_pop2");
    rd(3'd2, 1'b0, "fill_y_empty");

    // Reset with data pending everywhere
    wr(3'd4, 1'b1, "pend_a1");
    wr(3'd5, 1'b1, "pend_b1");
    wr(3'd4, 1'b1, "pend_a2");
    wr(3'd5, 1'b0, "pend_b2");
    wr(3'd4, 1'b0, "pend_a3");
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, "pend_rst");
    rd(3'd0, 1'b0, "post_rst_a");
    rd(3'd1, 1'b0, "post_rst_b");
    rd(3'd2, 1'b0, "post_rst_y");
    rd(3'd3, 1'b0, "post_rst_yout");

    // Randomised concurrent traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = 1'($urandom_range(0, 3) != 0);
      wa  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(4, 5));
      wd  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      step(rst, we, wa, wd, re, ra, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
